// File: rtl/uart_rx_decoder.sv
// Purpose: 8N1 (8E1 with UART_RX_PARITY_EN) UART receiver for the SoC console line, on wb_clk.
// Latency: rx_valid about 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after q falls (+CLKS_PER_BIT with parity).
// Backpressure: none; the sink must accept every rx_valid/frame_err/parity_err pulse as it occurs.
//
// Ports:
//   wb_clk      in      system clock, rising edge
//   wb_rst_n    in      asynchronous active-low reset
//   q           in      serial RX line, idle high, asynchronous to wb_clk
//   rx_data     out [8] last received byte (held between frames)
//   rx_valid    out     one-cycle pulse, rx_data holds a new good byte
//   frame_err   out     one-cycle pulse, stop bit sampled low
//   parity_err  out     one-cycle pulse, parity mismatch (constant 0 without UART_RX_PARITY_EN)
//   busy        out     high from start-bit detection until the FSM is back in IDLE
//   char_count  out [16] count of good bytes, wraps
//
// Optional feature macro: UART_RX_PARITY_EN (even parity bit between data and stop).

module uart_rx_decoder #(
  parameter int CLK_FREQ_HZ = 16_129_032,
  parameter int BAUD_RATE   = 57600
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        q,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        parity_err,
  output logic        busy,
  output logic [15:0] char_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Synchronizer flops reset to the idle (high) line level so reset release
  // never looks like a start bit.
  logic q_meta_q, q_meta_d;
  logic q_s_q, q_s_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic [15:0]      char_count_q, char_count_d;

`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             parity_err_q, parity_err_d;
`endif

  always_comb begin
    q_meta_d     = q;
    q_s_d        = q_meta_q;

    state_d      = state_q;
    cnt_d        = cnt_q + CNT_ONE;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    char_count_d = char_count_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!q_s_q) begin
          state_d = S_START;
        end
      end

      // Re-check the line at mid start bit; a high level here was a glitch.
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!q_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      // Counter was aligned to mid start bit, so a full bit period lands mid data bit.
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {q_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      // Even parity: the transmitted bit should equal the XOR of the data bits.
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_bad_d = q_s_q ^ (^shift_q);
          state_d   = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          rx_data_d = shift_q;
          if (q_s_q) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              rx_valid_d   = 1'b1;
              char_count_d = char_count_q + 16'd1;
            end
`else
            rx_valid_d   = 1'b1;
            char_count_d = char_count_q + 16'd1;
`endif
          end else begin
            // Framing error wins over any parity result.
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
        end
      end

      // A held-low line (break) must return high before a new start bit counts.
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (q_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Registered from the next state so busy falls in the cycle IDLE is entered.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      q_meta_q     <= 1'b1;
      q_s_q        <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      char_count_q <= 16'h0000;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      q_meta_q     <= q_meta_d;
      q_s_q        <= q_s_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      char_count_q <= char_count_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;
  assign char_count = char_count_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Purpose: self-checking bench for uart_rx_decoder with a scoreboard of expected bytes.
// Latency: frames driven at 280 clocks per bit; outputs sampled on the falling clock edge.
// Backpressure: none; every DUT pulse is consumed by the monitor as it appears.

module tb_uart_rx_decoder;

  localparam int CPB = 280;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_MIN = 2660 + CPB;
  localparam int LAT_MAX = 2805 + CPB;
`else
  localparam int LAT_MIN = 2660;
  localparam int LAT_MAX = 2805;
`endif

  logic        wb_clk;
  logic        wb_rst_n;
  logic        q;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        parity_err;
  logic        busy;
  logic [15:0] char_count;

  uart_rx_decoder dut (
    .wb_clk     (wb_clk),
    .wb_rst_n   (wb_rst_n),
    .q          (q),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy),
    .char_count (char_count)
  );

  initial wb_clk = 1'b0;
  always #31 wb_clk = ~wb_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int perr_cnt  = 0;
  int valid_cyc = 0;
  int fall_cyc  = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge wb_clk) cyc++;

  // Monitor: scoreboard pop on rx_valid, pulse counting, pulse exclusivity.
  always @(negedge wb_clk) begin
    if (rx_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else                   chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    end
    if (frame_err)  ferr_cnt++;
    if (parity_err) perr_cnt++;
    if (rx_valid || frame_err || parity_err)
      chk("pulse_excl", 32'(rx_valid) + 32'(frame_err) + 32'(parity_err), 32'd1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge wb_clk);
  endtask

  // Drive one frame; optionally checks busy in the middle of data bit 4.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                           input logic par_ovr, input logic par_val, input logic chk_busy);
    q = 1'b0;
    fall_cyc = cyc;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      q = b[i];
      if (i == 4 && chk_busy) begin
        wait_clks(CPB / 2);
        chk("busy_mid_frame", {31'd0, busy}, 32'd1);
        wait_clks(CPB - CPB / 2);
      end else begin
        wait_clks(CPB);
      end
    end
`ifdef UART_RX_PARITY_EN
    q = par_ovr ? par_val : ^b;
    wait_clks(CPB);
`endif
    q = stop_bit;
    wait_clks(CPB);
  endtask

  task automatic wait_valid(input int target, input string tag);
    int n;
    n = 0;
    while (valid_cnt < target && n < 1000) begin
      wait_clks(1);
      n++;
    end
    chk(tag, valid_cnt, target);
  endtask

  initial begin
    logic [7:0] abort_byte;
    int lat;
    int v_before;
    int c_before;

    wb_rst_n = 1'b0;
    q        = 1'b1;
    wait_clks(5);
    chk("rst_rx_data",    {24'd0, rx_data},    32'd0);
    chk("rst_rx_valid",   {31'd0, rx_valid},   32'd0);
    chk("rst_frame_err",  {31'd0, frame_err},  32'd0);
    chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    chk("rst_char_count", {16'd0, char_count}, 32'd0);
    wb_rst_n = 1'b1;
    wait_clks(20);

    // Single byte 0x55 with latency check.
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_valid(1, "valid_cnt_55");
    chk("char_count_55", {16'd0, char_count}, 32'd1);
    lat = valid_cyc - fall_cyc;
    chk("latency_55_in_window", {31'd0, (lat >= LAT_MIN && lat <= LAT_MAX)}, 32'd1);
    wait_clks(CPB);

    // "Hi\n" back to back.
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h69);
    exp_q.push_back(8'h0A);
    send_byte(8'h48, 1'b1, 1'b0, 1'b0, 1'b1);
    send_byte(8'h69, 1'b1, 1'b0, 1'b0, 1'b1);
    send_byte(8'h0A, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_valid(4, "valid_cnt_hi");
    chk("char_count_hi", {16'd0, char_count}, 32'd4);
    chk("last_data_hi",  {24'd0, rx_data},    32'h0A);
    wait_clks(CPB);

    // Start-bit glitch shorter than half a bit.
    v_before = valid_cnt;
    q = 1'b0;
    wait_clks(50);
    chk("glitch_busy_high", {31'd0, busy}, 32'd1);
    wait_clks(50);
    q = 1'b1;
    wait_clks(300);
    chk("glitch_busy_clear", {31'd0, busy}, 32'd0);
    chk("glitch_no_valid", valid_cnt, v_before);
    chk("glitch_no_ferr",  ferr_cnt,  32'd0);
    chk("glitch_rx_data_held", {24'd0, rx_data}, 32'h0A);

    // Framing error followed by a long break.
    send_byte(8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_clks(5000);
    chk("break_ferr_once",  ferr_cnt, 32'd1);
    chk("break_rx_data",    {24'd0, rx_data}, 32'hA3);
    chk("break_no_valid",   valid_cnt, v_before);
    chk("break_busy_held",  {31'd0, busy}, 32'd1);
    chk("break_char_count", {16'd0, char_count}, 32'd4);
    q = 1'b1;
    wait_clks(400);
    chk("break_busy_clear",   {31'd0, busy}, 32'd0);
    chk("break_no_more_ferr", ferr_cnt, 32'd1);
    chk("break_no_more_valid", valid_cnt, v_before);

    // Reset in the middle of data bit 4.
    abort_byte = 8'h7E;
    q = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin
      q = abort_byte[i];
      wait_clks(CPB);
    end
    q = abort_byte[4];
    wait_clks(100);
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    wb_rst_n = 1'b0;
    #1;
    chk("abort_rx_data",    {24'd0, rx_data},    32'd0);
    chk("abort_char_count", {16'd0, char_count}, 32'd0);
    chk("abort_busy",       {31'd0, busy},       32'd0);
    chk("abort_rx_valid",   {31'd0, rx_valid},   32'd0);
    chk("abort_frame_err",  {31'd0, frame_err},  32'd0);
    wait_clks(5);
    q = 1'b1;
    wait_clks(5);
    wb_rst_n = 1'b1;
    wait_clks(300);
    chk("abort_no_valid", valid_cnt, v_before);
    exp_q.push_back(8'h31);
    send_byte(8'h31, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_valid(v_before + 1, "valid_cnt_31");
    chk("char_count_31", {16'd0, char_count}, 32'd1);
    chk("rx_data_31",    {24'd0, rx_data},    32'h31);
    wait_clks(CPB);

`ifdef UART_RX_PARITY_EN
    // Bad parity: 0x01 needs parity 1.
    c_before = valid_cnt;
    send_byte(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_clks(400);
    chk("par_err_once",       perr_cnt,  32'd1);
    chk("par_err_no_valid",   valid_cnt, c_before);
    chk("par_err_char_count", {16'd0, char_count}, 32'd1);
    chk("par_err_rx_data",    {24'd0, rx_data},    32'h01);
    // Good parity: 0x03 has even parity 0.
    exp_q.push_back(8'h03);
    send_byte(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_valid(c_before + 1, "valid_cnt_03");
    chk("par_ok_char_count", {16'd0, char_count}, 32'd2);
    chk("par_ok_perr_count", perr_cnt, 32'd1);
`else
    c_before = valid_cnt;
    chk("no_parity_err_pulses", perr_cnt, 32'd0);
    chk("valid_total", c_before, 32'd5);
`endif

    wait_clks(50);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
